// File: rtl/banco_registradores_ula.sv
// Register bank and operand-issue stage ahead of the ULA: 8-entry register file,
// write-through bypass, a pending-destination scoreboard with stall, and a flag register.

// One architectural register with its scoreboard bit.
module banco_reg_slot #(
  parameter int BITS_PALAVRA = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr,
  input  logic [BITS_PALAVRA-1:0] wdata,
  input  logic                    set_pend,
  output logic [BITS_PALAVRA-1:0] q,
  output logic                    pend
);
  always_ff @(posedge clock) begin
    if (reset) begin
      q    <= '0;
      pend <= 1'b0;
    end else begin
      if (wr) q <= wdata;
      // A new reservation outranks the write-back of the previous producer.
      if (set_pend)  pend <= 1'b1;
      else if (wr)   pend <= 1'b0;
    end
  end
endmodule

module banco_registradores_ula #(
  parameter int BITS_PALAVRA = 16,
  parameter int NUM_REGS     = 8,
  parameter int ADDR_W       = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    emitir,
  input  logic [ADDR_W-1:0]       end_leituraA,
  input  logic [ADDR_W-1:0]       end_leituraB,
  input  logic                    reserva,
  input  logic [ADDR_W-1:0]       end_reserva,
  input  logic                    en_escrita,
  input  logic [ADDR_W-1:0]       end_escrita,
  input  logic [BITS_PALAVRA-1:0] dado_escrita,
  input  logic                    en_flags,
  input  logic                    Z,
  input  logic                    C,
  input  logic                    S,
  input  logic                    O,
  output logic [BITS_PALAVRA-1:0] operandoA,
  output logic [BITS_PALAVRA-1:0] operandoB,
  output logic                    operandos_validos,
  output logic [3:0]              flags,
  output logic                    bloqueio,
  output logic [NUM_REGS-1:0]     pendentes
);
  wire  [NUM_REGS-1:0][BITS_PALAVRA-1:0] regs;
  wire  [NUM_REGS-1:0]                   pend_q;
  logic [NUM_REGS-1:0]                   wr_sel, res_sel, pe;
  logic [BITS_PALAVRA-1:0]               val_a, val_b;
  logic                                  aceito, vld_q;
  wire  [1:0]                            vld_pipe;

  assign regs[0]   = '0;
  assign pend_q[0] = 1'b0;

  generate
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_slot
      banco_reg_slot #(.BITS_PALAVRA(BITS_PALAVRA)) u_slot (
        .clock    (clock),
        .reset    (reset),
        .wr       (wr_sel[i]),
        .wdata    (dado_escrita),
        .set_pend (res_sel[i]),
        .q        (regs[i]),
        .pend     (pend_q[i])
      );
    end
  endgenerate

  always_comb begin
    wr_sel = '0;
    if (en_escrita) wr_sel[end_escrita] = 1'b1;
    wr_sel[0] = 1'b0;
  end

  // A same-cycle write-back resolves the hazard it would otherwise raise.
  assign pe       = pend_q & ~wr_sel;
  assign bloqueio = emitir & (pe[end_leituraA] | pe[end_leituraB] | (reserva & pe[end_reserva]));
  assign aceito   = emitir & ~bloqueio;

  always_comb begin
    res_sel = '0;
    if (aceito && reserva) res_sel[end_reserva] = 1'b1;
    res_sel[0] = 1'b0;
  end

  always_comb begin
    val_a = regs[end_leituraA];
    if (en_escrita && end_escrita == end_leituraA) val_a = dado_escrita;
    if (end_leituraA == '0) val_a = '0;
    val_b = regs[end_leituraB];
    if (en_escrita && end_escrita == end_leituraB) val_b = dado_escrita;
    if (end_leituraB == '0) val_b = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      operandoA <= '0;
      operandoB <= '0;
      vld_q     <= 1'b0;
      flags     <= 4'b0000;
    end else begin
      if (aceito) begin
        operandoA <= val_a;
        operandoB <= val_b;
      end
      vld_q <= aceito;
      if (en_flags) flags <= {Z, C, S, O};
    end
  end

  assign vld_pipe          = {vld_q, aceito};
  assign operandos_validos = vld_pipe[1];
  assign pendentes         = pend_q;
endmodule

// File: tb/tb_banco_registradores_ula.sv
// Randomized bench for banco_registradores_ula: behavioural model compared every cycle,
// plus a directed sequence with literal expectations.
module tb_banco_registradores_ula;
  logic        clock = 1'b0, reset = 1'b1;
  logic        emitir = 0, reserva = 0, en_escrita = 0, en_flags = 0;
  logic [2:0]  end_leituraA = 0, end_leituraB = 0, end_reserva = 0, end_escrita = 0;
  logic [15:0] dado_escrita = 0;
  logic        Z = 0, C = 0, S = 0, O = 0;
  logic [15:0] operandoA, operandoB;
  logic        operandos_validos, bloqueio;
  logic [3:0]  flags;
  logic [7:0]  pendentes;

  banco_registradores_ula dut (
    .clock(clock), .reset(reset), .emitir(emitir),
    .end_leituraA(end_leituraA), .end_leituraB(end_leituraB),
    .reserva(reserva), .end_reserva(end_reserva),
    .en_escrita(en_escrita), .end_escrita(end_escrita), .dado_escrita(dado_escrita),
    .en_flags(en_flags), .Z(Z), .C(C), .S(S), .O(O),
    .operandoA(operandoA), .operandoB(operandoB), .operandos_validos(operandos_validos),
    .flags(flags), .bloqueio(bloqueio), .pendentes(pendentes)
  );

  always #5 clock = ~clock;

  // Behavioural model
  logic [15:0] m_reg [8];
  logic [7:0]  m_pend = 0;
  logic [15:0] m_opA = 0, m_opB = 0;
  logic        m_vld = 0;
  logic [3:0]  m_flags = 0;
  int          n_err = 0, n_chk = 0, lit_id = 0;
  bit          chk_en = 0;

  function automatic logic [15:0] m_val(input logic [2:0] a);
    if (a == 0) return 16'h0;
    if (en_escrita && end_escrita == a) return dado_escrita;
    return m_reg[a];
  endfunction

  function automatic logic m_stall();
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = m_pend[i] && !(en_escrita && end_escrita == i);
    return emitir && (p[end_leituraA] || p[end_leituraB] || (reserva && p[end_reserva]));
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_reg[i] <= 16'h0;
      m_pend <= 0; m_opA <= 0; m_opB <= 0; m_vld <= 0; m_flags <= 0;
    end else begin
      m_vld <= emitir && !m_stall();
      if (emitir && !m_stall()) begin
        m_opA <= m_val(end_leituraA);
        m_opB <= m_val(end_leituraB);
      end
      if (en_escrita && end_escrita != 0) begin
        m_reg[end_escrita]  <= dado_escrita;
        m_pend[end_escrita] <= 1'b0;
      end
      if (emitir && !m_stall() && reserva && end_reserva != 0) m_pend[end_reserva] <= 1'b1;
      if (en_flags) m_flags <= {Z, C, S, O};
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Compare process: model every cycle, literal pins on directed cycles
  always @(negedge clock) begin
    if (chk_en) begin
      chk("operandoA", operandoA, m_opA);
      chk("operandoB", operandoB, m_opB);
      chk("operandos_validos", {15'b0, operandos_validos}, {15'b0, m_vld});
      chk("flags", {12'b0, flags}, {12'b0, m_flags});
      chk("pendentes", {8'b0, pendentes}, {8'b0, m_pend});
      chk("bloqueio", {15'b0, bloqueio}, {15'b0, m_stall()});
      case (lit_id)
        1: begin
          chk("lit_reset_opA", operandoA, 16'h0); chk("lit_reset_opB", operandoB, 16'h0);
          chk("lit_reset_vld", {15'b0, operandos_validos}, 16'h1);
          chk("lit_reset_flags", {12'b0, flags}, 16'h0); chk("lit_reset_pend", {8'b0, pendentes}, 16'h0);
        end
        2: begin chk("lit_r3_opA", operandoA, 16'h1234); chk("lit_r0_opB", operandoB, 16'h0); end
        3: begin chk("lit_r0_write_ignored", operandoA, 16'h0); end
        4: begin chk("lit_bypass_opA", operandoA, 16'h00A5); chk("lit_bypass_opB", operandoB, 16'h1234); end
        5: begin
          chk("lit_reserve_pend", {8'b0, pendentes}, 16'h0010);
          chk("lit_reserve_opA", operandoA, 16'h1234);
          chk("lit_raw_stall", {15'b0, bloqueio}, 16'h1);
        end
        6: begin
          chk("lit_stall_vld", {15'b0, operandos_validos}, 16'h0);
          chk("lit_stall_hold_opA", operandoA, 16'h1234); chk("lit_stall_hold_opB", operandoB, 16'h00A5);
          chk("lit_wb_unstall", {15'b0, bloqueio}, 16'h0);
        end
        7: begin
          chk("lit_wb_opA", operandoA, 16'h7FFF); chk("lit_wb_vld", {15'b0, operandos_validos}, 16'h1);
          chk("lit_wb_pend", {8'b0, pendentes}, 16'h0);
        end
        8: begin chk("lit_set_wins_pend", {8'b0, pendentes}, 16'h0040); chk("lit_flags", {12'b0, flags}, 16'h9); end
        9: begin chk("lit_flags_hold", {12'b0, flags}, 16'h9); end
        10: begin chk("lit_pre_reset_pend", {8'b0, pendentes}, 16'h005C); chk("lit_pre_reset_flags", {12'b0, flags}, 16'hF); end
        11: begin
          chk("lit_post_reset_pend", {8'b0, pendentes}, 16'h0); chk("lit_post_reset_flags", {12'b0, flags}, 16'h0);
          chk("lit_post_reset_vld", {15'b0, operandos_validos}, 16'h0);
          chk("lit_post_reset_bloqueio", {15'b0, bloqueio}, 16'h0);
        end
        default: ;
      endcase
    end
  end

  task automatic step();
    @(posedge clock); #1; lit_id = 0;
  endtask

  task automatic idle();
    emitir = 0; reserva = 0; en_escrita = 0; en_flags = 0;
    end_leituraA = 0; end_leituraB = 0; end_reserva = 0; end_escrita = 0;
    dado_escrita = 0; {Z, C, S, O} = 4'b0000;
  endtask

  task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic rs, input logic [2:0] r);
    emitir = 1; end_leituraA = a; end_leituraB = b; reserva = rs; end_reserva = r;
  endtask

  task automatic wb(input logic [2:0] e, input logic [15:0] d);
    en_escrita = 1; end_escrita = e; dado_escrita = d;
  endtask

  initial begin
    step(); step(); reset = 0; chk_en = 1;
    issue(3, 5, 0, 0); step();
    idle(); lit_id = 1; wb(3, 16'h1234); step();
    idle(); issue(3, 0, 0, 0); wb(0, 16'hFFFF); step();
    idle(); lit_id = 2; issue(0, 0, 0, 0); step();
    idle(); lit_id = 3; wb(2, 16'h00A5); issue(2, 3, 0, 0); step();
    idle(); lit_id = 4; issue(3, 2, 1, 4); step();
    idle(); lit_id = 5; issue(4, 0, 0, 0); step();
    idle(); lit_id = 6; issue(4, 0, 0, 0); wb(4, 16'h7FFF); step();
    idle(); lit_id = 7; issue(0, 0, 1, 6); wb(6, 16'hBEEF); en_flags = 1; {Z, C, S, O} = 4'b1001; step();
    idle(); lit_id = 8; step();
    idle(); lit_id = 9; issue(0, 0, 1, 2); en_flags = 1; {Z, C, S, O} = 4'b1111; step();
    idle(); issue(0, 0, 1, 3); step();
    idle(); issue(0, 0, 1, 4); step();
    idle(); lit_id = 10; reset = 1; issue(2, 0, 1, 5); wb(1, 16'h5555); en_flags = 1; {Z, C, S, O} = 4'b0110; step();
    idle(); reset = 0; lit_id = 11; issue(2, 3, 1, 4); step();
    idle(); step();

    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 99) == 0);
      emitir       = $urandom_range(0, 1);
      end_leituraA = 3'($urandom_range(0, 7));
      end_leituraB = 3'($urandom_range(0, 7));
      reserva      = $urandom_range(0, 1);
      end_reserva  = 3'($urandom_range(0, 7));
      en_escrita   = ($urandom_range(0, 2) != 0);
      end_escrita  = 3'($urandom_range(0, 7));
      dado_escrita = 16'($urandom);
      en_flags     = $urandom_range(0, 1);
      {Z, C, S, O} = 4'($urandom_range(0, 15));
      step();
    end
    reset = 0; idle(); step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/banco_registradores_ula.md
Name: banco_registradores_ula

Overview:
- Register bank and operand-issue stage that sits directly upstream of the ULA.
- Supplies operandoA/operandoB from an 8-entry register file.
- Accepts the ULA's resultadoOp as write-back and latches its Z/C/S/O flags into a flag register.
- Tracks pending destination registers in a scoreboard and raises a stall (bloqueio) on RAW/WAW hazards.

Parameters:
BITS_PALAVRA, 16, data word width; must match the ULA operand width
NUM_REGS, 8, number of registers; R0 is hardwired to zero
ADDR_W, 3, register address width, equal to log2(NUM_REGS)

Ports:
clock  in  1  single system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
emitir  in  1  issue request: capture operands and apply the reservation this cycle
end_leituraA  in  ADDR_W  source register address for operand A
end_leituraB  in  ADDR_W  source register address for operand B
reserva  in  1  the issued instruction writes a destination register
end_reserva  in  ADDR_W  destination register address to mark pending
en_escrita  in  1  write-back enable (ULA result valid)
end_escrita  in  ADDR_W  write-back register address
dado_escrita  in  BITS_PALAVRA  write-back data (ULA resultadoOp)
en_flags  in  1  latch the ULA flags this cycle
Z, C, S, O  in  1 each  ULA flag outputs
operandoA  out  BITS_PALAVRA  registered operand A to the ULA
operandoB  out  BITS_PALAVRA  registered operand B to the ULA
operandos_validos  out  1  registered; high for exactly one cycle after an accepted issue
flags  out  4  registered {Z,C,S,O}: bit3=Z, bit0=O
bloqueio  out  1  combinational stall indication
pendentes  out  NUM_REGS  scoreboard mask; bit 0 is always 0

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, named reset; clock is named clock.
- Reset state: reset high at an edge clears all registers, operandoA/B, flags and pendentes to 0, and sets operandos_validos=0. Reset overrides every simultaneous write, issue or flag event. Reset mid-stall leaves bloqueio=0 next cycle, because pendentes is clear.
- Scoreboard masking: effective pending mask pe = pendentes with the bit for end_escrita cleared when en_escrita=1. A same-cycle write-back resolves the hazard.
- Stall: bloqueio = emitir & (pe[end_leituraA] | pe[end_leituraB] | (reserva & pe[end_reserva])). R0 never contributes.
- Accepted issue (emitir=1, bloqueio=0): at the edge, operandoA <= value(end_leituraA), operandoB <= value(end_leituraB), operandos_validos <= 1.
  - value(a) = 0 if a==0.
  - Otherwise value(a) = dado_escrita if en_escrita and end_escrita==a (write-through bypass).
  - Otherwise value(a) = the stored register.
- Latency: one cycle from issue to operands.
- Not accepted (emitir=0 or bloqueio=1): operandoA/B hold their values and operandos_validos <= 0.
- Write-back: en_escrita=1 and end_escrita!=0 writes reg[end_escrita] <= dado_escrita and clears pendentes[end_escrita]. A write to R0 is ignored.
- Reservation: on an accepted issue with reserva=1 and end_reserva!=0, pendentes[end_reserva] <= 1. If the write-back in the same cycle targets the same address, the set wins: the new producer stays pending, while the data is still written.
- Flags: en_flags=1 gives flags <= {Z,C,S,O}; otherwise flags hold. Flags are independent of en_escrita.
- Multiple pending registers are allowed. There is no limit other than NUM_REGS.
- Write-back to a register that is not pending is legal. It writes the data and leaves the pending bit at 0.

Test Plan:
- Reset, then issue A=R3, B=R5 -> next cycle operandoA=0, operandoB=0, operandos_validos=1, flags=0000, pendentes=0.
- Write R3=16'h1234, then issue A=R3, B=R0 -> operandoA=16'h1234, operandoB=0. A write of 16'hFFFF to R0 followed by a read of R0 -> 0.
- Bypass: write R2=16'h00A5 in the same cycle as issue A=R2 -> operandoA=16'h00A5 on the next cycle.
- RAW stall: issue with reserva, end_reserva=R4 -> pendentes=8'h10. Then issue A=R4 -> bloqueio=1, operands held, operandos_validos=0. Write-back R4=16'h7FFF -> the same-cycle issue is accepted with operandoA=16'h7FFF, and pendentes=0.
- Reserve plus write to R6 in the same cycle -> R6 holds the new data and pendentes[6] stays 1. The en_flags pulse with Z=1,C=0,S=0,O=1 -> flags=1001, which holds when en_flags=0.
- Reset asserted while pendentes=8'h5C and flags=1111 -> next cycle all cleared, and bloqueio=0 for any issue.
